// File: rtl/bcd_timekeeper_pkg.sv
// Shared BCD types, field limits and hour-display helpers for the timekeeper.
package timekeeper_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SS_MAX  = 8'h59;
    localparam bcd2_t MM_MAX  = 8'h59;
    localparam bcd2_t HH_MAX  = 8'h23;
    localparam bcd2_t HH_NOON = 8'h12;

    // True only for two valid BCD digits not exceeding max.
    function automatic logic bcd_ok(input bcd2_t v, input bcd2_t max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    function automatic bcd2_t to_12h(input bcd2_t hh);
        logic [6:0] b;
        logic [6:0] lo;
        b  = 7'(hh[7:4]) * 7'd10 + 7'(hh[3:0]) - 7'd12;
        lo = (b >= 7'd10) ? b - 7'd10 : b;
        if (hh == 8'h00)
            return HH_NOON;
        else if (hh <= HH_NOON)
            return hh;
        else
            return {3'b000, (b >= 7'd10), lo[3:0]};
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD modulo counter; wrap is the combinational carry to the next field.
module bcd_counter2
    import timekeeper_pkg::*;
(
    input  logic  CLK100MHZ,
    input  logic  Reset,
    input  logic  inc,
    input  logic  clr,
    input  bcd2_t limit,
    output bcd2_t value,
    output logic  wrap
);

    assign wrap = inc && (value == limit);

    always_ff @(posedge CLK100MHZ) begin
        if (Reset || clr)
            value <= 8'h00;
        else if (wrap)
            value <= 8'h00;
        else if (inc) begin
            if (value[3:0] == 4'd9)
                value <= {value[7:4] + 4'd1, 4'h0};
            else
                value <= {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// HH:MM:SS BCD timekeeper with prescaler, manual set, 12/24 h display and latched alarm.
module bcd_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int DIV      = 100_000_000,
    parameter bit ALARM_EN = 1'b1
) (
    input  logic  CLK100MHZ,
    input  logic  Reset,
    input  logic  run,
    input  logic  inc_min,
    input  logic  inc_hrs,
    input  logic  mode_12h,
    input  bcd2_t alarm_hh,
    input  bcd2_t alarm_mm,
    input  logic  alarm_on,
    input  logic  alarm_clr,
    output bcd2_t hours,
    output bcd2_t minutes,
    output bcd2_t seconds,
    output logic  pm,
    output logic  sec_tick,
    output logic  alarm
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;
    logic          manual, tick;
    logic          ss_wrap, mm_wrap, hh_wrap;
    bcd2_t         ss, mm, hh;

    // Manual set owns the cycle: the tick is dropped so inc_min can never collide with a carry.
    assign manual = inc_min || inc_hrs;
    assign tick   = run && !manual && (presc == PW'(DIV - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            presc    <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            if (manual || tick)
                presc <= '0;
            else if (run)
                presc <= presc + 1'b1;
        end
    end

    bcd_counter2 u_ss (
        .CLK100MHZ(CLK100MHZ), .Reset(Reset), .inc(tick), .clr(manual),
        .limit(SS_MAX), .value(ss), .wrap(ss_wrap)
    );

    bcd_counter2 u_mm (
        .CLK100MHZ(CLK100MHZ), .Reset(Reset), .inc(ss_wrap || inc_min), .clr(1'b0),
        .limit(MM_MAX), .value(mm), .wrap(mm_wrap)
    );

    // Only a tick-driven minute wrap carries into hours; inc_min at 59 does not.
    bcd_counter2 u_hh (
        .CLK100MHZ(CLK100MHZ), .Reset(Reset), .inc((mm_wrap && tick) || inc_hrs), .clr(1'b0),
        .limit(HH_MAX), .value(hh), .wrap(hh_wrap)
    );

    assign hours   = mode_12h ? to_12h(hh) : hh;
    assign pm      = (hh >= HH_NOON);
    assign seconds = ss;
    assign minutes = mm;

    generate
        if (ALARM_EN) begin : g_alarm
            logic match, match_q, alarm_r;

            assign match = alarm_on && bcd_ok(alarm_hh, HH_MAX) && bcd_ok(alarm_mm, MM_MAX)
                        && (hh == alarm_hh) && (mm == alarm_mm) && (ss == 8'h00);

            // match_q makes the alarm edge-triggered on entry, so a clear sticks while the match persists.
            always_ff @(posedge CLK100MHZ) begin
                if (Reset) begin
                    alarm_r <= 1'b0;
                    match_q <= 1'b0;
                end else begin
                    match_q <= match;
                    if (!alarm_on || alarm_clr)
                        alarm_r <= 1'b0;
                    else if (match && !match_q)
                        alarm_r <= 1'b1;
                end
            end

            assign alarm = alarm_r;
        end else begin : g_no_alarm
            assign alarm = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Scoreboard bench for bcd_timekeeper (DIV=4): behavioural model pushes expectations, monitor pops and checks.
module tb_bcd_timekeeper;

    localparam int DIV = 4;

    logic       CLK100MHZ = 1'b0;
    logic       Reset, run, inc_min, inc_hrs, mode_12h, alarm_on, alarm_clr;
    logic [7:0] alarm_hh, alarm_mm, hours, minutes, seconds;
    logic       pm, sec_tick, alarm;

    bcd_timekeeper #(.DIV(DIV), .ALARM_EN(1'b1)) dut (
        .CLK100MHZ(CLK100MHZ), .Reset(Reset), .run(run), .inc_min(inc_min), .inc_hrs(inc_hrs),
        .mode_12h(mode_12h), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_on(alarm_on),
        .alarm_clr(alarm_clr), .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
        .sec_tick(sec_tick), .alarm(alarm)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        logic [7:0] hours, minutes, seconds;
        logic       pm, tick, alarm;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0;

    int m_h, m_m, m_s, m_p;
    bit m_tick, m_alarm, m_matchq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int dec(input logic [7:0] b, output bit ok);
        ok = (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] disp(input int h, input logic m12);
        int d;
        if (!m12) return bcd(h);
        d = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
        return bcd(d);
    endfunction

    // One clock: drive inputs at the negedge, advance the model, queue the expected post-edge state.
    task automatic cyc(input bit r, input bit rn, input bit im, input bit ih, input bit clr);
        bit   okh, okm, match;
        int   ah, am;
        exp_t e;
        Reset = r; run = rn; inc_min = im; inc_hrs = ih; alarm_clr = clr;
        ah = dec(alarm_hh, okh);
        am = dec(alarm_mm, okm);
        match = alarm_on && okh && okm && ah <= 23 && am <= 59 && ah == m_h && am == m_m && m_s == 0;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_p = 0; m_tick = 0; m_alarm = 0; m_matchq = 0;
        end else begin
            if (!alarm_on || clr) m_alarm = 0;
            else if (match && !m_matchq) m_alarm = 1;
            m_matchq = match;
            m_tick = 0;
            if (im || ih) begin
                if (ih) m_h = (m_h + 1) % 24;
                if (im) m_m = (m_m + 1) % 60;
                m_s = 0; m_p = 0;
            end else if (rn) begin
                if (m_p == DIV - 1) begin
                    m_p = 0; m_tick = 1; m_s++;
                    if (m_s == 60) begin
                        m_s = 0; m_m++;
                        if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
                    end
                end else m_p++;
            end
        end
        e.hours = disp(m_h, mode_12h); e.minutes = bcd(m_m); e.seconds = bcd(m_s);
        e.pm = (m_h >= 12); e.tick = m_tick; e.alarm = m_alarm;
        q.push_back(e);
        @(negedge CLK100MHZ);
    endtask

    always @(posedge CLK100MHZ) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_hours", hours, e.hours);
            chk("sb_minutes", minutes, e.minutes);
            chk("sb_seconds", seconds, e.seconds);
            chk("sb_pm", pm, e.pm);
            chk("sb_tick", sec_tick, e.tick);
            chk("sb_alarm", alarm, e.alarm);
        end
    end

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic set_time(input int h, input int m);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < h; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < m; i++) cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        Reset = 1; run = 0; inc_min = 0; inc_hrs = 0; mode_12h = 0;
        alarm_hh = 8'h00; alarm_mm = 8'h00; alarm_on = 0; alarm_clr = 0;
        @(negedge CLK100MHZ);

        // Reset dominates pulses and run
        cyc(1, 1, 1, 1, 0);
        chk("reset_time", {hours, minutes, seconds}, 24'h000000);
        chk("reset_tick_alarm", {sec_tick, alarm}, 2'b00);

        // 1: free run
        run_n(236);
        chk("t1_ss59", {minutes, seconds}, 16'h0059);
        run_n(4);
        chk("t1_rollover", {minutes, seconds}, 16'h0100);

        // 2: 23:59:59 -> 00:00:00
        set_time(23, 59);
        run_n(236 + 3);
        chk("t2_pre", {hours, minutes, seconds, 7'b0, pm}, 32'h23595901);
        run_n(1);
        chk("t2_wrap", {hours, minutes, seconds, 7'b0, pm}, 32'h00000000);

        // 3: 12 h display
        mode_12h = 1;
        set_time(0, 0);
        #1 chk("t3_h00", {hours, 7'b0, pm}, 16'h1200);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);
        #1 chk("t3_h12", {hours, 7'b0, pm}, 16'h1201);
        cyc(0, 0, 0, 1, 0);
        #1 chk("t3_h13", {hours, 7'b0, pm}, 16'h0101);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        #1 chk("t3_h23", {hours, 7'b0, pm}, 16'h1101);
        mode_12h = 0;
        #1 chk("t3_back24", hours, 8'h23);

        // 4: inc_min at 59 has no carry; inc_min on the prescaler wrap kills the tick
        set_time(5, 59);
        run_n(10);
        cyc(0, 0, 1, 0, 0);
        chk("t4_mm_wrap", {hours, minutes, seconds}, 24'h050000);
        run_n(3);
        cyc(0, 1, 1, 0, 0);
        chk("t4_no_tick", {minutes, seconds, 7'b0, sec_tick}, 24'h010000);
        cyc(0, 1, 1, 1, 0);
        chk("t4_both", {hours, minutes, seconds}, 24'h060200);

        // 5: alarm 07:30
        alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_on = 1;
        set_time(7, 29);
        run_n(240);
        chk("t5_at_match", {minutes, seconds, 7'b0, alarm}, 24'h300000);
        run_n(1);
        chk("t5_fired", alarm, 1'b1);
        cyc(0, 1, 0, 0, 1);
        chk("t5_cleared", alarm, 1'b0);
        run_n(4);
        chk("t5_stays_clear", {seconds, 7'b0, alarm}, 16'h0100);
        alarm_hh = 8'h24; alarm_mm = 8'h00;
        set_time(23, 59);
        run_n(250);
        chk("t5_bad_hh", alarm, 1'b0);
        alarm_on = 0;

        // 6: pause, then reset mid-count
        set_time(3, 4);
        run_n(6);
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 0);
        chk("t6_frozen", {hours, minutes, seconds}, 24'h030401);
        run_n(2);
        cyc(1, 1, 0, 0, 0);
        chk("t6_reset", {hours, minutes, seconds}, 24'h000000);
        run_n(8);

        @(negedge CLK100MHZ);
        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
